fixed_div_seq: RTL and testbench

FIXED_DIV_SEQ -- requirements
Module: fixed_div_seq

---
 rtl/fixed_div_seq.sv | 213 +++++++++++++++++++++
 tb/tb_fixed_div_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_div_seq.sv
// fixed_div_seq: sequential fixed-point divider.
//
// Computes {q,f} = (n * 2^FRAC) / d as a (WIDTH+FRAC)-bit fixed-point value
// by restoring division. One quotient bit is resolved per clock, MSB first.
// Unsigned mode truncates (floor). Signed mode divides magnitudes and
// truncates toward zero. Division by zero returns a saturated code at once.
//
// Parameters
//   WIDTH  : operand width, and width of the result integer part
//   FRAC   : number of result fraction bits (>= 1)
//   SIGNED : 0 = unsigned operands, 1 = two's-complement operands/result
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair offered
//   in_ready   out  divider idle and able to accept operands
//   n          in   numerator (dividend)
//   d          in   denominator (divisor)
//   out_valid  out  result available
//   out_ready  in   downstream accepts the result
//   q          out  result integer part
//   f          out  result fractional part
//   div_zero   out  result was produced from d == 0
//   ovf        out  signed result saturated to the largest positive value

module fixed_div_seq #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 32,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [FRAC-1:0]  f,
    output logic             div_zero,
    output logic             ovf
);

    localparam int TOT = WIDTH + FRAC;
    localparam int CW  = $clog2(TOT);

    localparam logic [CW-1:0]  LAST_ITER = CW'(TOT - 1);
    localparam logic [TOT-1:0] MAX_POS   = {1'b0, {(TOT-1){1'b1}}};
    localparam logic [TOT-1:0] MIN_NEG   = {1'b1, {(TOT-1){1'b0}}};
    localparam logic [TOT-1:0] ALL_ONES  = {TOT{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // shreg starts as the shifted dividend magnitude; quotient bits enter at
    // the LSB while dividend bits leave at the MSB, so after TOT shifts it
    // holds the quotient magnitude.
    logic [TOT-1:0]   shreg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dmag;
    logic             neg;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             n_neg;
    logic             d_neg;
    logic             d_zero;
    logic [WIDTH-1:0] n_mag;
    logic [WIDTH-1:0] d_mag;
    logic             last;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt;
    logic [TOT-1:0]   shreg_nxt;

    logic [TOT-1:0]   res;
    logic             res_ovf;
    logic [TOT-1:0]   dz_res;

    assign accept = in_valid & in_ready;
    assign last   = (cnt == LAST_ITER);

    // Operand signs and magnitudes; the magnitude of the most negative value
    // still fits in WIDTH unsigned bits.
    assign n_neg  = (SIGNED != 0) & n[WIDTH-1];
    assign d_neg  = (SIGNED != 0) & d[WIDTH-1];
    assign n_mag  = n_neg ? (~n + 1'b1) : n;
    assign d_mag  = d_neg ? (~d + 1'b1) : d;
    assign d_zero = (d == '0);

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted remainder fits in WIDTH+1 bits and the sign of the trial
    // subtraction decides the quotient bit.
    always_comb begin
        rem_sh    = {rem, shreg[TOT-1]};
        trial     = rem_sh - {1'b0, dmag};
        qbit      = ~trial[WIDTH];
        rem_nxt   = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        shreg_nxt = {shreg[TOT-2:0], qbit};
    end

    // Final sign fix-up applied on the BUSY -> DONE edge. A negative result
    // never needs saturation: its magnitude is at most 2^(TOT-1).
    always_comb begin
        res     = shreg_nxt;
        res_ovf = 1'b0;
        if (SIGNED != 0) begin
            if (neg) begin
                res = ~shreg_nxt + 1'b1;
            end else if (shreg_nxt[TOT-1]) begin
                res     = MAX_POS;
                res_ovf = 1'b1;
            end
        end
    end

    // Division-by-zero code, decided from the operands presented at accept.
    always_comb begin
        if (SIGNED != 0) begin
            dz_res = n_neg ? MIN_NEG : MAX_POS;
        end else begin
            dz_res = ALL_ONES;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = d_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Iteration datapath: load on accept, shift once per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            rem   <= '0;
            dmag  <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= {n_mag, {FRAC{1'b0}}};
            rem   <= '0;
            dmag  <= d_mag;
            neg   <= n_neg ^ d_neg;
            cnt   <= '0;
        end else if (state == BUSY) begin
            shreg <= shreg_nxt;
            rem   <= rem_nxt;
            cnt   <= last ? '0 : cnt + CW'(1);
        end
    end

    // Result registers only move when a result is produced, so they stay
    // stable through DONE until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            f        <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept && d_zero) begin
            {q, f}   <= dz_res;
            div_zero <= 1'b1;
            ovf      <= 1'b0;
        end else if ((state == BUSY) && last) begin
            {q, f}   <= res;
            div_zero <= 1'b0;
            ovf      <= res_ovf;
        end
    end

endmodule

// File: tb/tb_fixed_div_seq.sv
// tb_fixed_div_seq: testbench for fixed_div_seq with WIDTH=8, FRAC=8.
// One unsigned and one signed instance share all inputs, so every
// transaction is checked in both modes against an arithmetic model.

module tb_fixed_div_seq;

    localparam int W = 8;
    localparam int F = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] n;
    logic [W-1:0] d;

    logic         u_in_ready, u_out_valid, u_dz, u_ovf;
    logic [W-1:0] u_q;
    logic [F-1:0] u_f;
    logic         s_in_ready, s_out_valid, s_dz, s_ovf;
    logic [W-1:0] s_q;
    logic [F-1:0] s_f;

    int errors = 0;
    int checks = 0;

    fixed_div_seq #(.WIDTH(W), .FRAC(F), .SIGNED(0)) u_dut_unsigned (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (u_in_ready),
        .n         (n),
        .d         (d),
        .out_valid (u_out_valid),
        .out_ready (out_ready),
        .q         (u_q),
        .f         (u_f),
        .div_zero  (u_dz),
        .ovf       (u_ovf)
    );

    fixed_div_seq #(.WIDTH(W), .FRAC(F), .SIGNED(1)) u_dut_signed (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .n         (n),
        .d         (d),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .q         (s_q),
        .f         (s_f),
        .div_zero  (s_dz),
        .ovf       (s_ovf)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void modelDiv(input bit sgn, input logic [W-1:0] an,
                                     input logic [W-1:0] ad,
                                     output logic [15:0] res,
                                     output logic dz, output logic ov);
        int nv, dv, qv;
        dz = 1'b0;
        ov = 1'b0;
        if (!sgn) begin
            nv = int'(an);
            dv = int'(ad);
            if (dv == 0) begin
                res = 16'hFFFF;
                dz  = 1'b1;
            end else begin
                res = 16'((nv * 256) / dv);
            end
        end else begin
            nv = int'($signed(an));
            dv = int'($signed(ad));
            if (dv == 0) begin
                dz  = 1'b1;
                res = (nv >= 0) ? 16'h7FFF : 16'h8000;
            end else begin
                qv = (nv * 256) / dv;
                if (qv > 32767) begin
                    qv = 32767;
                    ov = 1'b1;
                end
                res = 16'(qv);
            end
        end
    endfunction

    // Runs one transaction: offers operands, scrambles inputs while the
    // divider works, checks latency and results, holds the result for
    // 'hold' cycles, then releases it.
    task automatic applyStimulus(input logic [W-1:0] an, input logic [W-1:0] ad,
                                 input int hold);
        logic [15:0] eu, es;
        logic        dzu, ovu, dzs, ovs;
        int          lat;
        int          exp_lat;
        modelDiv(1'b0, an, ad, eu, dzu, ovu);
        modelDiv(1'b1, an, ad, es, dzs, ovs);
        exp_lat = (ad == 0) ? 0 : W + F;

        @(negedge clk);
        n         = an;
        d         = ad;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!u_out_valid && lat < 100) begin
            if (lat == 4) begin
                checkOutput("in_ready_busy", 32'({u_in_ready, s_in_ready}), 32'h0);
            end
            in_valid = 1'($urandom_range(0, 1));
            n        = 8'($urandom);
            d        = 8'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;

        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("s_out_valid", 32'(s_out_valid), 32'h1);
        checkOutput("u_result", 32'({u_q, u_f}), 32'(eu));
        checkOutput("u_flags", 32'({u_dz, u_ovf}), 32'({dzu, ovu}));
        checkOutput("s_result", 32'({s_q, s_f}), 32'(es));
        checkOutput("s_flags", 32'({s_dz, s_ovf}), 32'({dzs, ovs}));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            n = 8'($urandom);
            d = 8'($urandom);
            checkOutput("hold_valid", 32'({u_out_valid, s_out_valid}), 32'h3);
            checkOutput("hold_data", {u_q, u_f, s_q, s_f}, {eu, es});
            checkOutput("hold_flags", 32'({u_dz, u_ovf, s_dz, s_ovf}),
                        32'({dzu, ovu, dzs, ovs}));
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("release", 32'({u_out_valid, s_out_valid, u_in_ready, s_in_ready}),
                    32'h3);
    endtask

    // Starts a division, resets in its 8th BUSY cycle, and confirms that
    // the operation is abandoned without delivering a result.
    task automatic abortMidBusy(input logic [W-1:0] an, input logic [W-1:0] ad);
        int seen;
        @(negedge clk);
        n         = an;
        d         = ad;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'({u_out_valid, s_out_valid}), 32'h0);
        checkOutput("abort_data", {u_q, u_f, s_q, s_f}, 32'h0);
        checkOutput("abort_in_ready", 32'({u_in_ready, s_in_ready}), 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (u_out_valid || s_out_valid) seen++;
        end
        checkOutput("abort_no_result", 32'(seen), 32'h0);
    endtask

    initial begin
        logic [W-1:0] rn, rd;
        int           rh;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n         = '0;
        d         = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'({u_in_ready, s_in_ready}), 32'h3);
        checkOutput("reset_flags", 32'({u_out_valid, s_out_valid, u_dz, s_dz, u_ovf, s_ovf}),
                    32'h0);
        checkOutput("reset_data", {u_q, u_f, s_q, s_f}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        applyStimulus(8'h07, 8'h02, 0);
        applyStimulus(8'h01, 8'h03, 0);
        applyStimulus(8'hF9, 8'h02, 0);
        applyStimulus(8'hFF, 8'h03, 0);
        applyStimulus(8'h80, 8'hFF, 0);
        applyStimulus(8'h05, 8'h00, 0);
        applyStimulus(8'hF0, 8'h00, 1);
        applyStimulus(8'h00, 8'h00, 0);
        applyStimulus(8'h80, 8'h01, 0);
        applyStimulus(8'hFF, 8'h01, 0);
        applyStimulus(8'h64, 8'h07, 5);

        $display("[TB] reset during BUSY");
        abortMidBusy(8'hC8, 8'h03);
        applyStimulus(8'h09, 8'h04, 0);

        $display("[TB] random vectors");
        for (int k = 0; k < 40; k++) begin
            rn = 8'($urandom);
            rd = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            rh = int'($urandom_range(0, 2));
            applyStimulus(rn, rd, rh);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
